// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operation encoding and status-flag bundle.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SLT  = 3'b101,
      OP_SLTU = 3'b110,
      OP_SRL  = 3'b111
   } op_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU core: result and status flags for one operand pair.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  op_e              op_i,
   output logic [WIDTH-1:0] result_o,
   output flags_t           flags_o
);

   logic        [WIDTH:0]   sum_w;
   logic        [WIDTH:0]   diff_w;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic                    slt_w;
   logic                    sltu_w;

   // Bit WIDTH of the widened difference is the borrow, not an inverted carry.
   assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
   assign diff_w = {1'b0, a_i} - {1'b0, b_i};
   assign a_s    = a_i;
   assign b_s    = b_i;
   assign slt_w  = a_s < b_s;
   assign sltu_w = a_i < b_i;

   always_comb begin
      result_o         = '0;
      flags_o          = '0;
      unique case (op_i)
         OP_ADD: begin
            result_o         = sum_w[WIDTH-1:0];
            flags_o.carry    = sum_w[WIDTH];
            flags_o.overflow = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_w[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            result_o         = diff_w[WIDTH-1:0];
            flags_o.carry    = diff_w[WIDTH];
            flags_o.overflow = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_w[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, slt_w};
         OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, sltu_w};
         OP_SRL:  result_o = a_i >> b_i[SHW-1:0];
         default: result_o = '0;
      endcase
      flags_o.zero     = (result_o == '0);
      flags_o.negative = result_o[WIDTH-1];
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register (S1) feeding the core, result register (S2).
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   logic             vld_p1_q, vld_p1_d;
   logic             vld_p2_q, vld_p2_d;
   logic [WIDTH-1:0] a_p1_q, b_p1_q;
   op_e              op_p1_q;
   logic [WIDTH-1:0] res_w, res_p2_q;
   flags_t           flags_w, flags_p2_q;
   logic             s2_ready, accept, advance;

   // No skid buffer: in_ready is combinational from out_ready so a full pipe drains and refills in one cycle.
   assign s2_ready = !vld_p2_q || out_ready;
   assign in_ready = !vld_p1_q || s2_ready;
   assign accept   = in_valid && in_ready;
   assign advance  = vld_p1_q && s2_ready;

   always_comb begin
      vld_p1_d = vld_p1_q;
      if (accept)
         vld_p1_d = 1'b1;
      else if (advance)
         vld_p1_d = 1'b0;
      vld_p2_d = vld_p2_q;
      if (advance)
         vld_p2_d = 1'b1;
      else if (out_ready)
         vld_p2_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
      end
   end

   // S1: operand register
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p1_q  <= a;
         b_p1_q  <= b;
         op_p1_q <= op_e'(op);
      end
   end

   alu_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .a_i      (a_p1_q),
      .b_i      (b_p1_q),
      .op_i     (op_p1_q),
      .result_o (res_w),
      .flags_o  (flags_w)
   );

   // S2: result register, cleared on reset so the outputs read zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_p2_q   <= '0;
         flags_p2_q <= '0;
      end else if (advance) begin
         res_p2_q   <= res_w;
         flags_p2_q <= flags_w;
      end
   end

   assign out_valid = vld_p2_q;
   assign result    = res_p2_q;
   assign carry_out = flags_p2_q.carry;
   assign overflow  = flags_p2_q.overflow;
   assign zero      = flags_p2_q.zero;
   assign negative  = flags_p2_q.negative;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=32 and WIDTH=8 against an integer-arithmetic reference model.
module tb_alu_pipe;

   localparam int W  = 32;
   localparam int W8 = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic          carry_out, overflow, zero, negative;
   logic [W-1:0]  a, b, result;
   logic [2:0]    op;
   logic          in_valid8, in_ready8, out_valid8, out_ready8;
   logic          carry_out8, overflow8, zero8, negative8;
   logic [W8-1:0] a8, b8, result8;
   logic [2:0]    op8;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry_out(carry_out), .overflow(overflow),
      .zero(zero), .negative(negative));

   alu_pipe #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .carry_out(carry_out8), .overflow(overflow8),
      .zero(zero8), .negative(negative8));

   typedef struct packed {
      logic [63:0] res;
      logic [3:0]  fl;
      logic [31:0] acc;
      logic        lat;
   } exp_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        lat;
   } beat_t;

   exp_t  q[$];
   exp_t  q8[$];
   beat_t sq[$];
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint sx(input longint unsigned x, input int w);
      if (((x >> (w - 1)) & 64'd1) != 0)
         return longint'(x) - (longint'(1) << w);
      return longint'(x);
   endfunction

   // Reference: {result[63:0], carry, overflow, zero, negative} from plain integer arithmetic.
   function automatic logic [67:0] model(input int w, input logic [2:0] o,
                                         input longint unsigned x, input longint unsigned y);
      longint unsigned mask = (64'd1 << w) - 64'd1;
      longint          sa   = sx(x, w);
      longint          sb   = sx(y, w);
      longint          smax = (longint'(1) << (w - 1)) - 1;
      longint          smin = -(longint'(1) << (w - 1));
      longint unsigned r    = 0;
      logic            c    = 1'b0;
      logic            v    = 1'b0;
      case (o)
         3'd0: begin r = x + y; c = (r > mask); v = (sa + sb > smax) || (sa + sb < smin); end
         3'd1: begin r = x - y; c = (x < y);    v = (sa - sb > smax) || (sa - sb < smin); end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: r = (sa < sb) ? 64'd1 : 64'd0;
         3'd6: r = (x < y) ? 64'd1 : 64'd0;
         default: r = x >> (y % longint'(w));
      endcase
      r = r & mask;
      return {r, c, v, (r == 0), (((r >> (w - 1)) & 64'd1) != 0)};
   endfunction

   // mode 0: out_ready high; mode 1: out_ready low for stream cycles 3..7; mode 2: out_ready low throughout
   task automatic run(input int mode, input int budget, output int stalls);
      int          k    = 0;
      bit          have = 0;
      beat_t       cur  = '0;
      exp_t        e;
      logic [67:0] m;
      stalls = 0;
      while ((sq.size() > 0 || have) && k < budget) begin
         @(negedge clk);
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(k >= 3 && k <= 7) : 1'b0;
         if (!have && sq.size() > 0) begin
            cur  = sq.pop_front();
            have = 1;
         end
         in_valid = have;
         a        = cur.a;
         b        = cur.b;
         op       = cur.op;
         #1;
         if (have && !in_ready) stalls++;
         if (have && in_ready) begin
            m     = model(W, cur.op, 64'(cur.a), 64'(cur.b));
            e.res = m[67:4];
            e.fl  = m[3:0];
            e.acc = 32'(cyc + 1);
            e.lat = cur.lat;
            q.push_back(e);
            have  = 0;
         end
         k++;
      end
      if (have) check("stream_budget", 64'(sq.size() + 1), 64'd0);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = (mode != 2);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q.size() > 0 || q8.size() > 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 64'(q.size() + q8.size()), 64'd0);
   endtask

   task automatic one(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int s;
      sq.push_back('{op: o, a: x, b: y, lat: 1'b1});
      run(0, 20, s);
      drain(20);
   endtask

   task automatic send8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      exp_t        e;
      logic [67:0] m;
      @(negedge clk);
      in_valid8 = 1'b1;
      a8        = x;
      b8        = y;
      op8       = o;
      #1;
      check("in_ready8", 64'(in_ready8), 64'd1);
      if (in_ready8) begin
         m     = model(W8, o, 64'(x), 64'(y));
         e.res = m[67:4];
         e.fl  = m[3:0];
         e.acc = 32'(cyc + 1);
         e.lat = 1'b1;
         q8.push_back(e);
      end
   endtask

   // Monitor, WIDTH=32: checks every output handshake and stall stability.
   initial begin
      bit          stall = 0;
      logic [35:0] held  = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            stall = 0;
         end else begin
            if (stall && out_valid)
               check("stall_hold", 64'({result, carry_out, overflow, zero, negative}), 64'(held));
            stall = out_valid && !out_ready;
            held  = {result, carry_out, overflow, zero, negative};
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  check("unexpected_out", 64'({result, carry_out, overflow, zero, negative}), 64'd0);
                  if (failures == 0) begin
                     failures++;
                     $display("FAIL unexpected_out: got beat with empty scoreboard, expected none");
                  end
               end else begin
                  e = q.pop_front();
                  check("beat32", 64'({result, carry_out, overflow, zero, negative}),
                        64'({e.res[W-1:0], e.fl}));
                  if (e.lat) check("latency32", 64'(cyc + 1 - int'(e.acc)), 64'd2);
               end
            end
         end
      end
   end

   // Monitor, WIDTH=8.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out8: got result %0h with empty scoreboard, expected none", result8);
            end else begin
               e = q8.pop_front();
               check("beat8", 64'({result8, carry_out8, overflow8, zero8, negative8}),
                     64'({e.res[W8-1:0], e.fl}));
               if (e.lat) check("latency8", 64'(cyc + 1 - int'(e.acc)), 64'd2);
            end
         end
      end
   end

   initial begin
      int s;
      rst        = 1'b1;
      in_valid   = 1'b0; a  = '0; b  = '0; op  = '0; out_ready  = 1'b0;
      in_valid8  = 1'b0; a8 = '0; b8 = '0; op8 = '0; out_ready8 = 1'b1;
      #1;
      check("reset_outputs", 64'({out_valid, result, carry_out, overflow, zero, negative}), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;

      one(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
      one(3'd1, 32'h0000_0003, 32'h0000_0005);
      one(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
      one(3'd5, 32'hFFFF_FFFF, 32'h0000_0001);
      one(3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
      one(3'd7, 32'h8000_0000, 32'h0000_003F);
      one(3'd1, 32'h8000_0000, 32'h0000_0001);

      for (int i = 0; i < 6; i++)
         sq.push_back('{op: 3'($urandom_range(0, 7)), a: $urandom, b: $urandom, lat: 1'b0});
      run(1, 40, s);
      check("bp_in_ready_dropped", 64'(s > 0), 64'd1);
      drain(30);

      for (int i = 0; i < 100; i++)
         sq.push_back('{op: 3'($urandom_range(0, 7)), a: $urandom, b: $urandom, lat: 1'b1});
      run(0, 110, s);
      check("tput_no_stall", 64'(s), 64'd0);
      drain(10);

      sq.push_back('{op: 3'd0, a: 32'h1234_5678, b: 32'h1111_1111, lat: 1'b0});
      sq.push_back('{op: 3'd4, a: 32'hFFFF_0000, b: 32'h0F0F_0F0F, lat: 1'b0});
      run(2, 10, s);
      check("pre_reset_full", 64'({out_valid, in_ready}), 64'b10);
      #3 rst = 1'b1;
      #1;
      check("async_reset_outputs", 64'({out_valid, result, carry_out, overflow, zero, negative}), 64'd0);
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_reset_ready", 64'({in_ready, out_valid}), 64'b10);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      one(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);

      send8(3'd0, 8'hFF, 8'h01);
      send8(3'd1, 8'h03, 8'h05);
      send8(3'd0, 8'h7F, 8'h01);
      send8(3'd5, 8'hFF, 8'h01);
      send8(3'd6, 8'hFF, 8'h01);
      send8(3'd7, 8'h80, 8'h3F);
      for (int i = 0; i < 20; i++)
         send8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      @(negedge clk);
      in_valid8 = 1'b0;
      drain(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU that succeeds the fixed 32-bit combinational add/sub/and unit. It extends it with a configurable datapath width, eight operations, a full status-flag set, and valid/ready handshakes on both sides with full-throughput backpressure. It sits between the issue logic and writeback in the RISC-V datapath.

## Interface
- WIDTH, 32, datapath width in bits; power of two, 8 to 64.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for SRL, the shift amount is b[SHW-1:0].
- op  in  3  operation select; encoding is given under Operation.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- carry_out  out  1  carry (ADD) or borrow (SUB); 0 for all other ops.
- overflow  out  1  signed overflow (ADD/SUB); 0 for all other ops.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].

## Operation
- Op encoding:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed a<b gives 1, else 0, zero-extended.
  - 110 SLTU: unsigned a<b, zero-extended.
  - 111 SRL: a >> b[SHW-1:0], logical.
- ADD and SUB are computed at width WIDTH+1. carry_out is bit WIDTH of the wide result.
  - On SUB, carry_out=1 exactly when a<b unsigned, i.e. it is a borrow, not an inverted carry.
- overflow:
  - ADD: a and b have the same sign and the result sign differs.
  - SUB: a and b have different signs and the result sign differs from a.
- zero and negative are derived from the final result for every op.
- Stage 1 (S1) is the operand register: it captures a, b and op on an in_valid && in_ready handshake.
- Stage 2 (S2) is the output register: it captures the ALU core output and flags from S1.
- Each stage has its own valid bit.
- Ready chain:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready. This is combinational from out_ready; there is no skid buffer.
- S1 advances into S2 when s1_valid && s2_ready.
- S1 loads a new beat in the same cycle it drains: back-to-back beats with zero bubbles.
- While out_valid && !out_ready, result and all flags hold stable and no beat is lost or duplicated.
- in_valid with in_ready low: the beat is not taken. The upstream must hold a, b and op stable until the handshake.

## Timing
- Latency: a beat accepted at edge N appears on out_valid at edge N+2, provided out_ready was high throughout.
- Throughput: 1 beat per cycle under continuous in_valid and out_ready.
- Reset (asynchronous, takes effect immediately):
  - s1_valid=0 and out_valid=0.
  - result, carry_out, overflow, zero and negative all read 0.
  - in_ready=1 as soon as rst deasserts.
- Reset mid-operation discards both in-flight beats. No output pulse is produced on exit from reset.
- Full pipeline: both stages valid and out_ready=0 gives in_ready=0.
  - Raising out_ready drains S2 and S1 moves up in the same cycle.
  - in_ready rises combinationally in that cycle.
- Empty pipeline: out_valid=0 and in_ready=1. The datapath registers may hold stale data, but out_valid gates it.
- Simultaneous accept and emit in one cycle are both legal and must both take effect.

## Structure
- Package alu_pkg holds:
  - the op_e enum (ADD..SRL, values as above);
  - the flag struct (carry, overflow, zero, negative).
- Sub-module alu_core: purely combinational WIDTH-parametrised core (a, b, op → result, flags), instantiated between S1 and S2.
- The pipeline valid/ready control lives in alu_pipe.

## Test plan
- WIDTH=32, ADD a=0xFFFFFFFF b=0x00000001 → result=0, carry_out=1, zero=1, overflow=0. out_valid asserts 2 cycles after the handshake.
- SUB a=0x00000003 b=0x00000005 → result=0xFFFFFFFE, carry_out=1 (borrow), negative=1. Then ADD a=0x7FFFFFFF b=1 → result=0x80000000, overflow=1.
- SLT a=0xFFFFFFFF b=1 → result=1. SLTU with the same operands → result=0. SRL a=0x80000000 b=0x0000003F → result=1.
- Backpressure: stream 6 beats with out_ready low for cycles 3-7.
  - in_ready must drop once both stages fill.
  - Results must emerge in order, with no loss or duplication.
  - The held output must stay stable while stalled.
- Full throughput: 100 random beats with in_valid and out_ready tied high → one result per cycle, matching the scoreboard, with zero bubbles.
- Async reset asserted mid-stream with 2 beats in flight → out_valid and flags go to 0 immediately. in_ready=1 after deassert, and no stale beat is ever emitted.
- Repeat the arithmetic cases with WIDTH=8 (ADD 0xFF+0x01 → carry_out=1, zero=1).
